// File: rtl/hr_timing_pkg.sv
// Shared timing constants, scheduler state encoding and prescaler sizing helpers
// for the heart-rhythm timing blocks.
package hr_timing_pkg;

  localparam int CLK_HZ_DEFAULT  = 50000000;
  localparam int TICK_HZ_DEFAULT = 1000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sched_state_e;

  // Clock cycles per tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler counter width for a given divide ratio (never below one bit).
  function automatic int calc_div_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/ms_timer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above the pointer,
// wrapping, wins; returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          valid
);

  int cand_s;

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      if (!valid && req[cand_s]) begin
        valid        = 1'b1;
        gnt[cand_s]  = 1'b1;
        gnt_idx      = IW'(cand_s);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ms_timer_scheduler.sv
// Millisecond timebase plus NUM_CH timeout channels serviced by one shared
// decrementer that sweeps every channel after each tick.
module ms_timer_scheduler
  import hr_timing_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEFAULT,
  parameter int TICK_HZ = TICK_HZ_DEFAULT,
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH*CNT_W-1:0] dur_i,
  output logic [NUM_CH-1:0]       ack_o,
  output logic [NUM_CH-1:0]       expire_o,
  output logic [NUM_CH-1:0]       active_o,
  output logic                    tick_o
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = calc_div_w(DIV);
  localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if ((CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
    $error("CLK_HZ must be an integer multiple of TICK_HZ");
  end
  if ((NUM_CH < 1) || (NUM_CH >= DIV)) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1 and below CLK_HZ/TICK_HZ");
  end

  logic [PW-1:0]                   presc_r;
  logic                            tick_s;
  sched_state_e                    state_r, state_n;
  logic [IW-1:0]                   idx_r, idx_n;
  logic [IW-1:0]                   rr_ptr_r, rr_ptr_n;
  logic                            tick_pend_r, tick_pend_n;
  logic [NUM_CH-1:0]               ack_r, ack_n;
  logic [NUM_CH-1:0]               expire_r, expire_n;
  logic [NUM_CH-1:0]               active_r, active_n;
  logic [NUM_CH-1:0][CNT_W-1:0]    rem_r, rem_n;
  logic [NUM_CH-1:0][CNT_W-1:0]    dur_s;
  logic [NUM_CH-1:0]               eff_req_s;
  logic [NUM_CH-1:0]               gnt_s;
  logic [IW-1:0]                   gnt_idx_s;
  logic                            gnt_valid_s;

  assign dur_s  = dur_i;
  assign tick_s = (presc_r == PW'(DIV - 1));
  assign tick_o = tick_s;

  // A request still high while its ack pulse is out is the same request, not a new one.
  assign eff_req_s = req_i & ~ack_r;

  rr_arbiter #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_arb (
    .req     (eff_req_s),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .valid   (gnt_valid_s)
  );

  // Free-running tick prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Next-state logic: tick sweep takes priority over load grants.
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    rr_ptr_n    = rr_ptr_r;
    tick_pend_n = tick_pend_r | tick_s;
    ack_n       = '0;
    expire_n    = '0;
    active_n    = active_r;
    rem_n       = rem_r;
    case (state_r)
      IDLE: begin
        if (tick_pend_r) begin
          state_n     = SWEEP;
          idx_n       = '0;
          tick_pend_n = tick_s;
        end else if (gnt_valid_s) begin
          ack_n    = gnt_s;
          rr_ptr_n = (gnt_idx_s == IW'(NUM_CH - 1)) ? {IW{1'b0}} : gnt_idx_s + IW'(1);
          for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_s[i]) begin
              // A zero duration cancels: remaining becomes 0 and the channel disarms.
              rem_n[i]    = dur_s[i];
              active_n[i] = (dur_s[i] != {CNT_W{1'b0}});
            end else begin
              rem_n[i]    = rem_r[i];
              active_n[i] = active_r[i];
            end
          end
        end else begin
          state_n = IDLE;
        end
      end
      SWEEP: begin
        if (active_r[idx_r]) begin
          if (rem_r[idx_r] == CNT_W'(1)) begin
            rem_n[idx_r]    = '0;
            active_n[idx_r] = 1'b0;
            expire_n[idx_r] = 1'b1;
          end else begin
            rem_n[idx_r] = rem_r[idx_r] - CNT_W'(1);
          end
        end else begin
          rem_n[idx_r] = rem_r[idx_r];
        end
        if (idx_r == IW'(NUM_CH - 1)) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx_r + IW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // Scheduler state, channel register file and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      rr_ptr_r    <= '0;
      tick_pend_r <= 1'b0;
      ack_r       <= '0;
      expire_r    <= '0;
      active_r    <= '0;
      rem_r       <= '0;
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      rr_ptr_r    <= rr_ptr_n;
      tick_pend_r <= tick_pend_n;
      ack_r       <= ack_n;
      expire_r    <= expire_n;
      active_r    <= active_n;
      rem_r       <= rem_n;
    end
  end

  assign ack_o    = ack_r;
  assign expire_o = expire_r;
  assign active_o = active_r;

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Directed bench for ms_timer_scheduler at DIV=10, four channels; expected
// ack/expire pulses are queued at drive time and matched by a negedge monitor.
module tb_ms_timer_scheduler;

  localparam int DIV    = 10;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;

  typedef struct {
    int   kind;
    int   ch;
    int   cyc;
    logic act;
  } ev_t;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*CNT_W-1:0] dur;
  logic [NUM_CH-1:0]       ack_o;
  logic [NUM_CH-1:0]       expire_o;
  logic [NUM_CH-1:0]       active_o;
  logic                    tick_o;

  int  cyc;
  int  checks;
  int  failures;
  ev_t sb[$];

  ms_timer_scheduler #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .dur_i    (dur),
    .ack_o    (ack_o),
    .expire_o (expire_o),
    .active_o (active_o),
    .tick_o   (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int first_tick_ge(input int g);
    return g + (DIV - 1) - (g % DIV);
  endfunction

  // Grant in cycle g with duration d: expiry visible 3+ch cycles after the d-th tick.
  function automatic int exp_cyc(input int g, input int d, input int ch);
    return first_tick_ge(g) + DIV * (d - 1) + 3 + ch;
  endfunction

  task automatic sb_push(input int kind, input int ch, input int c, input logic act);
    ev_t e;
    e.kind = kind; e.ch = ch; e.cyc = c; e.act = act;
    sb.push_back(e);
  endtask

  task automatic check_event(input int kind, input int ch);
    int hit;
    hit = -1;
    foreach (sb[k]) begin
      if (hit < 0 && sb[k].kind == kind && sb[k].ch == ch && sb[k].cyc == cyc) hit = k;
    end
    checks++;
    assert (hit >= 0) else begin
      failures++;
      $error("FAIL %s_ch%0d unexpected pulse at cyc=%0d observed=1 expected=0",
             (kind == 0) ? "ack" : "expire", ch, cyc);
    end
    if (hit >= 0) begin
      checks++;
      assert (active_o[ch] === sb[hit].act) else begin
        failures++;
        $error("FAIL %s_ch%0d_active cyc=%0d observed=%b expected=%b",
               (kind == 0) ? "ack" : "expire", ch, cyc, active_o[ch], sb[hit].act);
      end
      sb.delete(hit);
    end
  endtask

  // Monitor: tick cadence every cycle, every ack/expire pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_tick;
      exp_tick = (cyc % DIV) == (DIV - 1);
      checks++;
      assert (tick_o === exp_tick) else begin
        failures++;
        $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, tick_o, exp_tick);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (ack_o[c] === 1'b1)    check_event(0, c);
        if (expire_o[c] === 1'b1) check_event(1, c);
      end
    end
  end

  task automatic chk4(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic sb_drain();
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_missing pending observed=%0d expected=0 first_kind=%0d first_ch=%0d first_cyc=%0d",
             sb.size(), sb[0].kind, sb[0].ch, sb[0].cyc);
    end
    sb.delete();
  endtask

  // Requester behaviour: drop req once its ack is seen.
  task automatic step();
    @(negedge clk);
    req = req & ~ack_o;
  endtask

  task automatic wait_until(input int t);
    int n;
    n = 0;
    while (cyc < t && n < 1000) begin
      step();
      n++;
    end
    checks++;
    assert (cyc === t) else begin
      failures++;
      $error("FAIL wait_until observed=%0d expected=%0d", cyc, t);
    end
  endtask

  task automatic set_dur(input int ch, input int d);
    dur[ch*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    req      = '0;
    dur      = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk4("rst_ack", ack_o, 4'b0000);
    chk4("rst_expire", expire_o, 4'b0000);
    chk4("rst_active", active_o, 4'b0000);
    chk4("rst_tick", {3'b000, tick_o}, 4'b0000);
    rst_n = 1'b1;

    // Idle run: ticks at 9, 19, 29, no pulses.
    wait_until(35);
    chk4("idle_active", active_o, 4'b0000);

    // All four request together, durations 1..4, pointer at 0.
    for (int i = 0; i < NUM_CH; i++) begin
      set_dur(i, i + 1);
      sb_push(0, i, 36 + i, 1'b1);
      sb_push(1, i, exp_cyc(35 + i, i + 1, i), 1'b0);
    end
    req = 4'b1111;
    wait_until(45);
    chk4("all4_active_after_t1", active_o, 4'b1110);
    wait_until(80);
    chk4("all4_active_done", active_o, 4'b0000);

    // Single load, dur=3.
    set_dur(0, 3);
    req[0] = 1'b1;
    sb_push(0, 0, 86, 1'b1);
    sb_push(1, 0, exp_cyc(85, 3, 0), 1'b0);
    wait_until(90);
    chk4("dur3_active", active_o, 4'b0001);
    wait_until(113);
    chk4("dur3_done", active_o, 4'b0000);

    // Request raised while a tick is pending waits out the sweep.
    wait_until(120);
    set_dur(2, 1);
    req[2] = 1'b1;
    sb_push(0, 2, 126, 1'b1);
    sb_push(1, 2, exp_cyc(125, 1, 2), 1'b0);
    wait_until(135);

    // Cancel, then reload-while-active.
    set_dur(1, 5);
    req[1] = 1'b1;
    sb_push(0, 1, 136, 1'b1);
    wait_until(155);
    chk4("ch1_armed", active_o, 4'b0010);
    set_dur(1, 0);
    req[1] = 1'b1;
    sb_push(0, 1, 156, 1'b0);
    wait_until(215);
    chk4("ch1_cancelled", active_o, 4'b0000);
    set_dur(1, 5);
    req[1] = 1'b1;
    sb_push(0, 1, 216, 1'b1);
    wait_until(225);
    set_dur(1, 2);
    req[1] = 1'b1;
    sb_push(0, 1, 226, 1'b1);
    sb_push(1, 1, exp_cyc(225, 2, 1), 1'b0);
    wait_until(240);
    chk4("ch1_reloaded", active_o, 4'b0010);
    wait_until(270);
    chk4("ch1_reload_done", active_o, 4'b0000);

    // Reset in the middle of a sweep with two channels about to expire.
    set_dur(0, 1);
    set_dur(3, 1);
    req = 4'b1001;
    sb_push(0, 3, 276, 1'b1);
    sb_push(0, 0, 277, 1'b1);
    wait_until(280);
    chk4("pre_reset_active", active_o, 4'b1001);
    sb_drain();
    wait_until(281);
    rst_n = 1'b0;
    #1;
    chk4("midsweep_rst_active", active_o, 4'b0000);
    chk4("midsweep_rst_expire", expire_o, 4'b0000);
    chk4("midsweep_rst_ack", ack_o, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_until(25);
    chk4("post_reset_active", active_o, 4'b0000);
    sb_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
